// File: rtl/acmp_monitor.sv
// Digital back end for the analog comparator: enable/settle sequencing, 2-flop
// synchroniser, glitch filter, sticky edge flags, interrupt and saturating edge counter.
module acmp_monitor #(
  parameter int SETTLE_CYCLES = 16,
  parameter int FILT_LEN      = 4,
  parameter int CNT_W         = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable_i,
  input  logic             cmp_out,
  output logic             cmp_en,
  input  logic             irq_rise_en,
  input  logic             irq_fall_en,
  input  logic             clr_i,
  output logic             level,
  output logic             valid,
  output logic             rise_flag,
  output logic             fall_flag,
  output logic             irq,
  output logic [CNT_W-1:0] edge_count,
  output logic [1:0]       dbg_state
);

  localparam int SW = (SETTLE_CYCLES > 0) ? $clog2(SETTLE_CYCLES + 1) : 1;
  localparam int FW = $clog2(FILT_LEN + 1);
  localparam logic [SW-1:0]    SETTLE_LOAD = SW'(SETTLE_CYCLES);
  localparam logic [FW-1:0]    FILT_LAST   = FW'(FILT_LEN - 1);
  localparam logic [CNT_W-1:0] CNT_MAX     = '1;

  typedef enum logic [1:0] {
    ST_OFF    = 2'd0,
    ST_SETTLE = 2'd1,
    ST_ACTIVE = 2'd2
  } state_t;

  state_t           state, state_n;
  logic             sync1, s;
  logic [SW-1:0]    settle_cnt, settle_cnt_n;
  logic [FW-1:0]    filt_cnt, filt_cnt_n;
  logic             level_n, toggle;
  logic             rise_n, fall_n;
  logic [CNT_W-1:0] count_n;

  always_comb begin
    state_n      = state;
    settle_cnt_n = settle_cnt;
    filt_cnt_n   = filt_cnt;
    level_n      = level;
    toggle       = 1'b0;
    case (state)
      ST_OFF: begin
        if (enable_i) begin
          if (SETTLE_CYCLES == 0) begin
            state_n    = ST_ACTIVE;
            level_n    = s;
            filt_cnt_n = '0;
          end else begin
            state_n      = ST_SETTLE;
            settle_cnt_n = SETTLE_LOAD;
          end
        end
      end
      ST_SETTLE: begin
        if (settle_cnt <= SW'(1)) begin
          // The entry load adopts the current sample without producing an edge.
          state_n    = ST_ACTIVE;
          level_n    = s;
          filt_cnt_n = '0;
        end else begin
          settle_cnt_n = settle_cnt - SW'(1);
        end
      end
      ST_ACTIVE: begin
        if (s != level) begin
          if (filt_cnt == FILT_LAST) begin
            toggle     = 1'b1;
            level_n    = ~level;
            filt_cnt_n = '0;
          end else begin
            filt_cnt_n = filt_cnt + FW'(1);
          end
        end else begin
          filt_cnt_n = '0;
        end
      end
      default: state_n = ST_OFF;
    endcase
    // Disable overrides everything; the forced level clear is not an edge.
    if (!enable_i) begin
      state_n      = ST_OFF;
      settle_cnt_n = '0;
      filt_cnt_n   = '0;
      level_n      = 1'b0;
      toggle       = 1'b0;
    end
  end

  always_comb begin
    rise_n  = clr_i ? 1'b0 : rise_flag;
    fall_n  = clr_i ? 1'b0 : fall_flag;
    count_n = clr_i ? '0 : edge_count;
    // An edge in the same cycle as clr_i survives the clear.
    if (toggle) begin
      if (level_n) rise_n = 1'b1;
      else         fall_n = 1'b1;
      if (count_n != CNT_MAX) count_n = count_n + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1      <= 1'b0;
      s          <= 1'b0;
      state      <= ST_OFF;
      settle_cnt <= '0;
      filt_cnt   <= '0;
      level      <= 1'b0;
      valid      <= 1'b0;
      cmp_en     <= 1'b0;
      rise_flag  <= 1'b0;
      fall_flag  <= 1'b0;
      edge_count <= '0;
    end else begin
      sync1      <= cmp_out;
      s          <= sync1;
      state      <= state_n;
      settle_cnt <= settle_cnt_n;
      filt_cnt   <= filt_cnt_n;
      level      <= level_n;
      valid      <= (state_n == ST_ACTIVE);
      cmp_en     <= (state_n != ST_OFF);
      rise_flag  <= rise_n;
      fall_flag  <= fall_n;
      edge_count <= count_n;
    end
  end

  assign irq       = (rise_flag & irq_rise_en) | (fall_flag & irq_fall_en);
  assign dbg_state = state;

endmodule

// File: tb/tb_acmp_monitor.sv
// Bench for acmp_monitor: two instances (default timing, and zero-settle/single-sample
// filter with a 4-bit counter) checked against a behavioural model of the comparator rules.
module tb_acmp_monitor;

  localparam int ST0 = 16, FL0 = 4, CW0 = 16;
  localparam int ST1 = 0,  FL1 = 1, CW1 = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [1:0] en, cmpo, clr, rme, fme;
  logic [1:0] cmp_en_o, lvl, vld, rf, ff, irq_o;
  logic [CW0-1:0] cnt0;
  logic [CW1-1:0] cnt1;
  logic [1:0] st0, st1;

  int n_vec, n_err;

  acmp_monitor #(.SETTLE_CYCLES(ST0), .FILT_LEN(FL0), .CNT_W(CW0)) dut0 (
    .clk(clk), .reset(rst), .enable_i(en[0]), .cmp_out(cmpo[0]), .cmp_en(cmp_en_o[0]),
    .irq_rise_en(rme[0]), .irq_fall_en(fme[0]), .clr_i(clr[0]), .level(lvl[0]),
    .valid(vld[0]), .rise_flag(rf[0]), .fall_flag(ff[0]), .irq(irq_o[0]),
    .edge_count(cnt0), .dbg_state(st0)
  );

  acmp_monitor #(.SETTLE_CYCLES(ST1), .FILT_LEN(FL1), .CNT_W(CW1)) dut1 (
    .clk(clk), .reset(rst), .enable_i(en[1]), .cmp_out(cmpo[1]), .cmp_en(cmp_en_o[1]),
    .irq_rise_en(rme[1]), .irq_fall_en(fme[1]), .clr_i(clr[1]), .level(lvl[1]),
    .valid(vld[1]), .rise_flag(rf[1]), .fall_flag(ff[1]), .irq(irq_o[1]),
    .edge_count(cnt1), .dbg_state(st1)
  );

  function automatic int settle_of(int i); return (i == 0) ? ST0 : ST1; endfunction
  function automatic int filt_of(int i);   return (i == 0) ? FL0 : FL1; endfunction
  function automatic int cmax_of(int i);   return (i == 0) ? ((1 << CW0) - 1) : ((1 << CW1) - 1); endfunction

  // Reference model: cycles-since-enable decides when the level is trusted; the level flips
  // once FILT_LEN consecutive trusted samples disagree with it.
  bit m_p1[2], m_p2[2], m_act[2], m_lvl[2], m_rf[2], m_ff[2];
  int m_on[2], m_run[2], m_cnt[2];

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 2; i++) begin
        m_p1[i] = 0; m_p2[i] = 0; m_act[i] = 0; m_lvl[i] = 0; m_rf[i] = 0; m_ff[i] = 0;
        m_on[i] = 0; m_run[i] = 0; m_cnt[i] = 0;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        bit smp;
        bit edge_now;
        edge_now = 0;
        smp = m_p2[i];
        m_p2[i] = m_p1[i];
        m_p1[i] = cmpo[i];
        if (!en[i]) begin
          m_on[i] = 0; m_act[i] = 0; m_lvl[i] = 0; m_run[i] = 0;
        end else if (!m_act[i]) begin
          m_on[i]++;
          if (m_on[i] > settle_of(i)) begin
            m_act[i] = 1; m_lvl[i] = smp; m_run[i] = 0;
          end
        end else begin
          m_run[i] = (smp != m_lvl[i]) ? m_run[i] + 1 : 0;
          if (m_run[i] == filt_of(i)) begin
            m_lvl[i] = ~m_lvl[i]; m_run[i] = 0; edge_now = 1;
          end
        end
        if (clr[i]) begin m_rf[i] = 0; m_ff[i] = 0; m_cnt[i] = 0; end
        if (edge_now) begin
          if (m_lvl[i]) m_rf[i] = 1; else m_ff[i] = 1;
          if (m_cnt[i] < cmax_of(i)) m_cnt[i]++;
        end
      end
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached, got running want finished");
    $fatal(1, "watchdog");
  end

  task automatic pulse_clr(int i);
    clr[i] = 1'b1;
    @(negedge clk);
    clr[i] = 1'b0;
  endtask

  task automatic test_reset;
    n_vec++;
    if ({cmp_en_o, lvl, vld, rf, ff, irq_o} !== 12'b0) begin
      n_err++; $display("FAIL reset_outputs: got %b want 0", {cmp_en_o, lvl, vld, rf, ff, irq_o});
    end
    n_vec++;
    if (cnt0 !== '0 || cnt1 !== '0) begin
      n_err++; $display("FAIL reset_count: got %0d/%0d want 0/0", cnt0, cnt1);
    end
    rst = 1'b0;
    repeat (2) @(negedge clk);
    n_vec++;
    if (cmp_en_o !== 2'b00 || vld !== 2'b00) begin
      n_err++; $display("FAIL idle_off: cmp_en=%b valid=%b want 00/00", cmp_en_o, vld);
    end
  endtask

  task automatic test_settle;
    int k;
    cmpo[0] = 1'b1;
    en[0] = 1'b1;
    @(negedge clk);
    n_vec++;
    if (cmp_en_o[0] !== 1'b1 || vld[0] !== 1'b0) begin
      n_err++; $display("FAIL settle_cmp_en: cmp_en=%b valid=%b want 1/0", cmp_en_o[0], vld[0]);
    end
    k = 0;
    while (vld[0] !== 1'b1 && k < 40) begin @(negedge clk); k++; end
    n_vec++;
    if (k != ST0) begin n_err++; $display("FAIL settle_time: got %0d cycles want %0d", k, ST0); end
    n_vec++;
    if (lvl[0] !== 1'b1 || rf[0] !== 1'b0 || cnt0 !== 16'd0) begin
      n_err++; $display("FAIL settle_load: level=%b rise=%b cnt=%0d want 1/0/0", lvl[0], rf[0], cnt0);
    end
  endtask

  task automatic test_step;
    int k;
    cmpo[0] = 1'b0;
    k = 0;
    while (lvl[0] !== 1'b0 && k < 20) begin @(negedge clk); k++; end
    n_vec++;
    if (lvl[0] !== 1'b0) begin n_err++; $display("FAIL step_prep: level=%b want 0", lvl[0]); end
    pulse_clr(0);
    n_vec++;
    if (rf[0] !== 1'b0 || ff[0] !== 1'b0 || cnt0 !== 16'd0) begin
      n_err++; $display("FAIL clr_plain: rise=%b fall=%b cnt=%0d want 0/0/0", rf[0], ff[0], cnt0);
    end
    rme[0] = 1'b1;
    cmpo[0] = 1'b1;
    k = 0;
    do begin @(negedge clk); k++; end while (lvl[0] !== 1'b1 && k < 20);
    n_vec++;
    if (k < 5 || k > 7) begin n_err++; $display("FAIL step_latency: got %0d want 6+-1", k); end
    n_vec++;
    if (rf[0] !== 1'b1 || ff[0] !== 1'b0 || cnt0 !== 16'd1 || irq_o[0] !== 1'b1) begin
      n_err++; $display("FAIL step_flags: rise=%b fall=%b cnt=%0d irq=%b want 1/0/1/1", rf[0], ff[0], cnt0, irq_o[0]);
    end
    rme[0] = 1'b0;
    @(negedge clk);
    n_vec++;
    if (irq_o[0] !== 1'b0) begin n_err++; $display("FAIL irq_masked: got %b want 0", irq_o[0]); end
  endtask

  task automatic test_glitch;
    int k;
    cmpo[0] = 1'b0;
    k = 0;
    while (lvl[0] !== 1'b0 && k < 20) begin @(negedge clk); k++; end
    repeat (3) @(negedge clk);
    pulse_clr(0);
    for (int p = 0; p < 5; p++) begin
      for (int c = 0; c < 7; c++) begin
        cmpo[0] = (c < FL0 - 1);
        @(negedge clk);
        n_vec++;
        if (lvl[0] !== 1'b0) begin n_err++; $display("FAIL glitch_level: pulse %0d got %b want 0", p, lvl[0]); end
      end
    end
    repeat (4) @(negedge clk);
    n_vec++;
    if (rf[0] !== 1'b0 || ff[0] !== 1'b0 || cnt0 !== 16'd0) begin
      n_err++; $display("FAIL glitch_flags: rise=%b fall=%b cnt=%0d want 0/0/0", rf[0], ff[0], cnt0);
    end
  endtask

  task automatic test_clr_edge;
    int k;
    cmpo[0] = 1'b1;
    k = 0;
    while (lvl[0] !== 1'b1 && k < 20) begin @(negedge clk); k++; end
    repeat (3) @(negedge clk);
    cmpo[0] = 1'b0;
    // Fall toggle lands on the 6th rising edge after this drive; clr_i is placed on it.
    repeat (5) @(negedge clk);
    pulse_clr(0);
    n_vec++;
    if (ff[0] !== 1'b1 || rf[0] !== 1'b0 || cnt0 !== 16'd1 || lvl[0] !== 1'b0) begin
      n_err++; $display("FAIL clr_with_edge: fall=%b rise=%b cnt=%0d level=%b want 1/0/1/0", ff[0], rf[0], cnt0, lvl[0]);
    end
  endtask

  task automatic test_enable_drop;
    int k;
    en[0] = 1'b0;
    @(negedge clk);
    n_vec++;
    if (cmp_en_o[0] !== 1'b0 || vld[0] !== 1'b0 || lvl[0] !== 1'b0) begin
      n_err++; $display("FAIL disable_off: cmp_en=%b valid=%b level=%b want 0/0/0", cmp_en_o[0], vld[0], lvl[0]);
    end
    cmpo[0] = 1'b1;
    en[0] = 1'b1;
    @(negedge clk);
    repeat (8) @(negedge clk);
    n_vec++;
    if (vld[0] !== 1'b0 || cmp_en_o[0] !== 1'b1) begin
      n_err++; $display("FAIL mid_settle: valid=%b cmp_en=%b want 0/1", vld[0], cmp_en_o[0]);
    end
    en[0] = 1'b0;
    @(negedge clk);
    n_vec++;
    if (cmp_en_o[0] !== 1'b0) begin n_err++; $display("FAIL settle_abort: cmp_en=%b want 0", cmp_en_o[0]); end
    en[0] = 1'b1;
    @(negedge clk);
    k = 0;
    while (vld[0] !== 1'b1 && k < 40) begin @(negedge clk); k++; end
    n_vec++;
    if (k != ST0) begin n_err++; $display("FAIL resettle_time: got %0d cycles want %0d", k, ST0); end
    n_vec++;
    if (lvl[0] !== 1'b1 || ff[0] !== 1'b1 || rf[0] !== 1'b0 || cnt0 !== 16'd1) begin
      n_err++; $display("FAIL reentry: level=%b fall=%b rise=%b cnt=%0d want 1/1/0/1", lvl[0], ff[0], rf[0], cnt0);
    end
    en[0] = 1'b0;
    @(negedge clk);
    n_vec++;
    if (lvl[0] !== 1'b0 || vld[0] !== 1'b0 || ff[0] !== 1'b1 || rf[0] !== 1'b0 || cnt0 !== 16'd1) begin
      n_err++; $display("FAIL active_drop: level=%b valid=%b fall=%b rise=%b cnt=%0d want 0/0/1/0/1", lvl[0], vld[0], ff[0], rf[0], cnt0);
    end
  endtask

  task automatic test_reset_mid;
    int k;
    cmpo[0] = 1'b0;
    en[0] = 1'b1;
    k = 0;
    while (vld[0] !== 1'b1 && k < 40) begin @(negedge clk); k++; end
    repeat (3) @(negedge clk);
    cmpo[0] = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    n_vec++;
    if (lvl[0] !== 1'b0 || vld[0] !== 1'b1) begin
      n_err++; $display("FAIL mid_filter: level=%b valid=%b want 0/1", lvl[0], vld[0]);
    end
    #1 rst = 1'b1;
    #1;
    n_vec++;
    if ({cmp_en_o, lvl, vld, rf, ff, irq_o} !== 12'b0 || cnt0 !== '0 || cnt1 !== '0) begin
      n_err++; $display("FAIL async_reset: got %b cnt=%0d/%0d want all 0", {cmp_en_o, lvl, vld, rf, ff, irq_o}, cnt0, cnt1);
    end
    en = 2'b00;
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    n_vec++;
    if (lvl[0] !== 1'b0 || cnt0 !== 16'd0 || rf[0] !== 1'b0) begin
      n_err++; $display("FAIL post_reset: level=%b cnt=%0d rise=%b want 0/0/0", lvl[0], cnt0, rf[0]);
    end
  endtask

  task automatic test_fast_path;
    int k;
    cmpo[1] = 1'b1;
    repeat (3) @(negedge clk);
    en[1] = 1'b1;
    @(negedge clk);
    n_vec++;
    if (vld[1] !== 1'b1 || cmp_en_o[1] !== 1'b1 || lvl[1] !== 1'b1) begin
      n_err++; $display("FAIL zero_settle: valid=%b cmp_en=%b level=%b want 1/1/1", vld[1], cmp_en_o[1], lvl[1]);
    end
    cmpo[1] = 1'b0;
    k = 0;
    do begin @(negedge clk); k++; end while (lvl[1] !== 1'b0 && k < 20);
    n_vec++;
    if (k != 3) begin n_err++; $display("FAIL fast_latency: got %0d want 3", k); end
    n_vec++;
    if (ff[1] !== 1'b1 || cnt1 !== 4'd1) begin
      n_err++; $display("FAIL fast_flags: fall=%b cnt=%0d want 1/1", ff[1], cnt1);
    end
  endtask

  task automatic test_saturate;
    int want;
    pulse_clr(1);
    for (int t = 1; t <= 20; t++) begin
      cmpo[1] = ~cmpo[1];
      repeat (4) @(negedge clk);
      want = (t > 15) ? 15 : t;
      n_vec++;
      if (cnt1 !== 4'(want)) begin n_err++; $display("FAIL saturate: toggle %0d got %0d want %0d", t, cnt1, want); end
    end
  endtask

  task automatic test_random;
    int hold[2];
    hold[0] = 1; hold[1] = 1;
    en = 2'b11;
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
        n_vec++;
        if (lvl[i] !== m_lvl[i] || vld[i] !== m_act[i] || cmp_en_o[i] !== ((m_on[i] > 0) || m_act[i]) ||
            rf[i] !== m_rf[i] || ff[i] !== m_ff[i] ||
            irq_o[i] !== ((m_rf[i] & rme[i]) | (m_ff[i] & fme[i]))) begin
          n_err++;
          $display("FAIL random_bits: dut%0d cyc %0d got lvl%b vld%b en%b r%b f%b irq%b want lvl%b vld%b r%b f%b",
                   i, c, lvl[i], vld[i], cmp_en_o[i], rf[i], ff[i], irq_o[i], m_lvl[i], m_act[i], m_rf[i], m_ff[i]);
        end
      end
      n_vec++;
      if (cnt0 !== 16'(m_cnt[0]) || cnt1 !== 4'(m_cnt[1])) begin
        n_err++; $display("FAIL random_count: cyc %0d got %0d/%0d want %0d/%0d", c, cnt0, cnt1, m_cnt[0], m_cnt[1]);
      end
      for (int i = 0; i < 2; i++) begin
        hold[i]--;
        if (hold[i] <= 0) begin
          cmpo[i] = ~cmpo[i];
          hold[i] = $urandom_range(1, 9);
        end
        clr[i] = ($urandom_range(0, 39) == 0);
        if ($urandom_range(0, 15) == 0) rme[i] = $urandom_range(0, 1);
        if ($urandom_range(0, 15) == 0) fme[i] = $urandom_range(0, 1);
        if (en[i]) en[i] = ($urandom_range(0, 299) != 0);
        else       en[i] = ($urandom_range(0, 9) == 0);
      end
    end
    clr = 2'b00;
  endtask

  initial begin
    rst = 1'b1;
    en = 2'b00; cmpo = 2'b00; clr = 2'b00; rme = 2'b00; fme = 2'b00;
    n_vec = 0; n_err = 0;
    repeat (3) @(negedge clk);
    test_reset;
    test_settle;
    test_step;
    test_glitch;
    test_clr_edge;
    test_enable_drop;
    test_reset_mid;
    test_fast_path;
    test_saturate;
    test_random;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/acmp_monitor.md
Name: acmp_monitor

Overview:
- Digital back end for the 3.3 V analog comparator.
- Drives the comparator enable and waits a fixed settling time after enable.
- Synchronises the asynchronous comparator output into the core clock domain, glitch-filters it, and produces a clean level.
- Produces sticky rise/fall flags, an interrupt, and a saturating edge counter for the SoC register block.

Parameters:
- SETTLE_CYCLES, 16: clk cycles from comparator enable until the output is trusted. 0 is legal.
- FILT_LEN, 4: consecutive identical synchronised samples required to change the filtered level. Must be ≥1.
- CNT_W, 16: width of the edge counter.

Ports:
- clk  input  1  core clock.
- reset  input  1  asynchronous, active-high reset.
- enable_i  input  1  software enable for the monitor and comparator.
- cmp_out  input  1  raw comparator output; asynchronous to clk; may be X while the comparator is disabled.
- cmp_en  output  1  registered enable to the comparator EN pin.
- irq_rise_en  input  1  rise-interrupt mask.
- irq_fall_en  input  1  fall-interrupt mask.
- clr_i  input  1  single-cycle pulse; clears rise_flag, fall_flag and edge_count.
- level  output  1  filtered comparator level.
- valid  output  1  high when level is meaningful (ACTIVE state).
- rise_flag  output  1  sticky flag: filtered 0→1 edge seen.
- fall_flag  output  1  sticky flag: filtered 1→0 edge seen.
- irq  output  1  (rise_flag & irq_rise_en) | (fall_flag & irq_fall_en); combinational from registers only.
- edge_count  output  CNT_W  count of filtered edges; saturates.

Behaviour:
- Reset values:
  - cmp_en=0, level=0, valid=0, rise_flag=0, fall_flag=0, edge_count=0, irq=0.
  - Synchroniser flops, filter counter and settle counter are 0.
  - FSM is in OFF.
- Synchroniser:
  - 2-flop chain on cmp_out, giving the sample s.
  - X on cmp_out is tolerated only while the FSM is not in ACTIVE. s is ignored outside ACTIVE.
- FSM states: OFF, SETTLE, ACTIVE. All outputs are registered.
- OFF:
  - cmp_en=0, valid=0, level=0.
  - enable_i=1 → next state SETTLE; cmp_en=1 next cycle; settle counter loaded with SETTLE_CYCLES.
  - If SETTLE_CYCLES=0, go directly to ACTIVE instead.
- SETTLE:
  - cmp_en=1.
  - Counter decrements each cycle.
  - When the counter reaches 1 → ACTIVE next cycle, so SETTLE lasts exactly SETTLE_CYCLES cycles.
- Entering ACTIVE:
  - level loads the current s; valid=1; filter counter=0.
  - No edge and no flag is generated by this load.
- ACTIVE, filter rule:
  - If s != level, the filter counter increments.
  - When the counter reaches FILT_LEN, level toggles on that clock and the counter returns to 0.
  - Any cycle with s == level clears the counter.
- Latency:
  - A clean step on cmp_out appears on level 2+FILT_LEN clk edges later (±1 for async sampling).
  - Pulses shorter than FILT_LEN cycles after synchronisation never reach level.
- Edges:
  - A level toggle 0→1 sets rise_flag; 1→0 sets fall_flag.
  - Every toggle increments edge_count by 1, saturating at 2^CNT_W−1 (no wrap).
- clr_i:
  - Clears both flags and edge_count in any state.
  - If clr_i coincides with an edge, the new edge wins: its flag is 1 afterwards and edge_count=1.
- enable_i=0, from any state:
  - FSM goes to OFF on the next clock; cmp_en=0, valid=0, level=0, filter counter=0.
  - This forced level clear is not an edge and does not change the flags or edge_count.
  - The flags and edge_count are retained until clr_i.
- enable_i dropped during SETTLE: abort to OFF. Re-enable restarts the full settle time.
- Asynchronous reset mid-operation: everything returns to its reset value immediately. No edge is counted.

Test Plan:
1. Reset, then enable_i=1 with cmp_out=1 → cmp_en=1 one cycle later; valid rises exactly 16 cycles after cmp_en; level=1; rise_flag=0; edge_count=0.
2. ACTIVE with level=0; cmp_out steps 0→1 and holds → level=1 after 6±1 cycles; rise_flag=1; edge_count=1; irq=1 with irq_rise_en=1, irq=0 with irq_rise_en=0.
3. ACTIVE with level=0; cmp_out pulses high for 3 cycles, 5 times → level stays 0; no flags; edge_count=0.
4. Force edge_count to 0xFFFE via 3 filtered edges after preloading by toggling; apply clr_i in the same cycle as a fall edge → fall_flag=1, rise_flag=0, edge_count=1. Separately, toggle past 0xFFFF → edge_count holds 0xFFFF.
5. enable_i dropped at SETTLE cycle 8, then reasserted → valid only after a fresh 16 cycles. Dropping enable_i in ACTIVE with level=1 → level=0 and valid=0 next cycle; flags and count unchanged.
6. Assert reset mid-filter (counter=3) → all outputs 0 immediately. Re-run with SETTLE_CYCLES=0 and FILT_LEN=1 → ACTIVE the cycle after enable; step latency 3 cycles.
